odin_aer_event_scheduler: RTL and testbench

- Sits between the OBI peripheral bus and the tinyODIN core's AER ports.
- Buffers event words written by the CPU and injects them into tinyODIN's AERIN port with a four-phase handshake, one at a time.
- Accepts output spikes from tinyODIN's AEROUT port with a four-phase handshake and queues them for CPU readout.
- Sequences all event traffic into and out of the neuromorphic core, applying backpressure on both sides.

---
 rtl/odin_aer_event_scheduler_if.sv | 20 ++
 rtl/odin_aer_event_scheduler.sv | 164 ++++++++++++++++
 tb/tb_odin_aer_event_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/odin_aer_event_scheduler_if.sv
// rtl/odin_aer_event_scheduler_if.sv - OBI peripheral bus bundle for the AER event scheduler
interface odin_aer_event_scheduler_if;
  logic        obi_req_i;
  logic        obi_we_i;
  logic [3:0]  obi_addr_i;
  logic [31:0] obi_wdata_i;
  logic        obi_gnt_o;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;

  modport master (
    output obi_req_i, obi_we_i, obi_addr_i, obi_wdata_i,
    input  obi_gnt_o, obi_rvalid_o, obi_rdata_o
  );

  modport slave (
    input  obi_req_i, obi_we_i, obi_addr_i, obi_wdata_i,
    output obi_gnt_o, obi_rvalid_o, obi_rdata_o
  );
endinterface

// File: rtl/odin_aer_event_scheduler.sv
// rtl/odin_aer_event_scheduler.sv - CPU-side event FIFOs and four-phase AER sequencing for tinyODIN
module odin_aer_event_scheduler #(
  parameter int M         = 8,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  odin_aer_event_scheduler_if.slave obi,
  output logic [2*M+1:0]       AERIN_ADDR,
  output logic                 AERIN_REQ,
  input  logic                 AERIN_ACK,
  input  logic [M-1:0]         AEROUT_ADDR,
  input  logic                 AEROUT_REQ,
  output logic                 AEROUT_ACK,
  output logic                 irq_o
);
  localparam int AW  = 2*M+2;
  localparam int IPW = $clog2(IN_DEPTH);
  localparam int OPW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {IN_IDLE, IN_WAIT_ACK, IN_WAIT_REL} in_state_e;
  typedef enum logic {OUT_IDLE, OUT_WAIT_REL} out_state_e;

  logic [AW-1:0]  in_mem_q  [IN_DEPTH];
  logic [M-1:0]   out_mem_q [OUT_DEPTH];
  logic [IPW-1:0] in_wptr_q, in_rptr_q;
  logic [OPW-1:0] out_wptr_q, out_rptr_q;
  logic [IPW:0]   in_count_q, in_count_d;
  logic [OPW:0]   out_count_q, out_count_d;
  in_state_e      in_state_q;
  out_state_e     out_state_q;
  logic [AW-1:0]  aerin_addr_q;
  logic           aerin_req_q, aerout_ack_q, irq_q;
  logic           irq_en_q, irq_en_d, flush_q, sticky_q, sticky_d;
  logic           rvalid_q;
  logic [31:0]    rdata_q, rdata_d;

  logic [1:0] sel;
  logic in_full, in_empty, out_full, out_empty, in_busy;
  logic in_pop, in_push, out_pop, out_push, out_accept, out_blocked;
  logic acc, wr_in, wr_status, wr_ctrl;
  logic unused_bits;

  assign sel       = obi.obi_addr_i[3:2];
  assign in_full   = (in_count_q == (IPW+1)'(IN_DEPTH));
  assign in_empty  = (in_count_q == '0);
  assign out_full  = (out_count_q == (OPW+1)'(OUT_DEPTH));
  assign out_empty = (out_count_q == '0);
  assign in_busy   = (in_state_q != IN_IDLE);

  // A pop in the same cycle frees a slot, so a write to a full FIFO is still granted.
  assign in_pop        = (in_state_q == IN_IDLE) && !in_empty && !flush_q;
  assign wr_in         = obi.obi_req_i && obi.obi_we_i && (sel == 2'd0);
  assign obi.obi_gnt_o = obi.obi_req_i && !(wr_in && in_full && !in_pop);
  assign acc           = obi.obi_req_i && obi.obi_gnt_o;
  assign in_push       = acc && obi.obi_we_i && (sel == 2'd0) && !flush_q;
  assign wr_status     = acc && obi.obi_we_i && (sel == 2'd2);
  assign wr_ctrl       = acc && obi.obi_we_i && (sel == 2'd3);
  assign out_pop       = acc && !obi.obi_we_i && (sel == 2'd1) && !out_empty;
  assign out_accept    = (out_state_q == OUT_IDLE) && AEROUT_REQ && !out_full;
  assign out_blocked   = (out_state_q == OUT_IDLE) && AEROUT_REQ && out_full;
  assign out_push      = out_accept && !flush_q;

  assign in_count_d  = flush_q ? '0 : in_count_q + (IPW+1)'(in_push) - (IPW+1)'(in_pop);
  assign out_count_d = flush_q ? '0 : out_count_q + (OPW+1)'(out_push) - (OPW+1)'(out_pop);
  assign irq_en_d    = wr_ctrl ? obi.obi_wdata_i[0] : irq_en_q;
  assign sticky_d    = out_blocked || (sticky_q && !(wr_status && obi.obi_wdata_i[19]));
  assign unused_bits = ^{obi.obi_wdata_i, obi.obi_addr_i[1:0]};

  always_comb begin
    rdata_d = '0;
    if (acc && !obi.obi_we_i) begin
      case (sel)
        2'd1: if (!out_empty) rdata_d = {1'b1, {(31-M){1'b0}}, out_mem_q[out_rptr_q]};
        2'd2: rdata_d = {12'd0, sticky_q, in_busy, out_empty, in_full,
                         8'(out_count_q), 8'(in_count_q)};
        2'd3: rdata_d = {31'd0, irq_en_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (in_push) in_mem_q[in_wptr_q] <= obi.obi_wdata_i[AW-1:0];
    if (out_push) out_mem_q[out_wptr_q] <= AEROUT_ADDR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_wptr_q    <= '0;
      in_rptr_q    <= '0;
      out_wptr_q   <= '0;
      out_rptr_q   <= '0;
      in_count_q   <= '0;
      out_count_q  <= '0;
      in_state_q   <= IN_IDLE;
      out_state_q  <= OUT_IDLE;
      aerin_addr_q <= '0;
      aerin_req_q  <= 1'b0;
      aerout_ack_q <= 1'b0;
      irq_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      flush_q      <= 1'b0;
      sticky_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rvalid_q    <= acc;
      rdata_q     <= rdata_d;
      irq_en_q    <= irq_en_d;
      flush_q     <= wr_ctrl && obi.obi_wdata_i[1];
      sticky_q    <= sticky_d;
      irq_q       <= irq_en_d && (out_count_d != '0);
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      if (flush_q) begin
        in_wptr_q  <= '0;
        in_rptr_q  <= '0;
        out_wptr_q <= '0;
        out_rptr_q <= '0;
      end else begin
        if (in_push)  in_wptr_q  <= in_wptr_q + 1'b1;
        if (in_pop)   in_rptr_q  <= in_rptr_q + 1'b1;
        if (out_push) out_wptr_q <= out_wptr_q + 1'b1;
        if (out_pop)  out_rptr_q <= out_rptr_q + 1'b1;
      end

      case (in_state_q)
        IN_IDLE: if (in_pop) begin
          aerin_addr_q <= in_mem_q[in_rptr_q];
          aerin_req_q  <= 1'b1;
          in_state_q   <= IN_WAIT_ACK;
        end
        IN_WAIT_ACK: if (AERIN_ACK) begin
          aerin_req_q <= 1'b0;
          in_state_q  <= IN_WAIT_REL;
        end
        IN_WAIT_REL: if (!AERIN_ACK) in_state_q <= IN_IDLE;
        default: in_state_q <= IN_IDLE;
      endcase

      // The ACK is raised even if a flush drops the spike, so tinyODIN never stalls.
      case (out_state_q)
        OUT_IDLE: if (out_accept) begin
          aerout_ack_q <= 1'b1;
          out_state_q  <= OUT_WAIT_REL;
        end
        OUT_WAIT_REL: if (!AEROUT_REQ) begin
          aerout_ack_q <= 1'b0;
          out_state_q  <= OUT_IDLE;
        end
        default: out_state_q <= OUT_IDLE;
      endcase
    end
  end

  assign obi.obi_rvalid_o = rvalid_q;
  assign obi.obi_rdata_o  = rdata_q;
  assign AERIN_ADDR       = aerin_addr_q;
  assign AERIN_REQ        = aerin_req_q;
  assign AEROUT_ACK       = aerout_ack_q;
  assign irq_o            = irq_q;
endmodule

// File: tb/tb_odin_aer_event_scheduler.sv
// tb/tb_odin_aer_event_scheduler.sv - scoreboard bench for the AER event scheduler
module tb_odin_aer_event_scheduler;
  localparam int M = 8;

  typedef struct {
    logic [31:0] val;
    logic [31:0] mask;
  } rsp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [17:0]   AERIN_ADDR;
  logic          AERIN_REQ;
  logic          AERIN_ACK = 1'b0;
  logic [7:0]    AEROUT_ADDR = '0;
  logic          AEROUT_REQ = 1'b0;
  logic          AEROUT_ACK;
  logic          irq_o;

  logic          auto_ack = 1'b0;
  logic          man_ack = 1'b0;
  logic          prev_req = 1'b0;
  int            checks = 0;
  int            failures = 0;
  int            aer_rises = 0;
  rsp_t          rsp_q[$];
  logic [17:0]   aer_q[$];

  odin_aer_event_scheduler_if bus();

  odin_aer_event_scheduler #(.M(M), .IN_DEPTH(8), .OUT_DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .obi(bus),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ), .AEROUT_ACK(AEROUT_ACK),
    .irq_o(irq_o)
  );

  always #5 CLK = ~CLK;

  // tinyODIN input side: either echoes REQ one cycle late or follows man_ack
  always @(posedge CLK) begin
    #1;
    AERIN_ACK = auto_ack ? AERIN_REQ : man_ack;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    rsp_t e;
    if (bus.obi_rvalid_o) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected actual=1 expected=0");
      end else begin
        e = rsp_q.pop_front();
        chk("obi_rdata", bus.obi_rdata_o & e.mask, e.val & e.mask);
      end
    end
    if (AERIN_REQ && !prev_req) begin
      aer_rises++;
      if (aer_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL aerin_unexpected_req actual=0x%05h expected=none", AERIN_ADDR);
      end else begin
        chk("aerin_addr", 32'(AERIN_ADDR), 32'(aer_q.pop_front()));
      end
    end
    prev_req = AERIN_REQ;
  end

  task automatic obi(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp, input logic [31:0] mask);
    int w = 0;
    rsp_t e;
    bus.obi_req_i   = 1'b1;
    bus.obi_we_i    = we;
    bus.obi_addr_i  = addr;
    bus.obi_wdata_i = wd;
    @(negedge CLK);
    while (!bus.obi_gnt_o && w < 200) begin
      w++;
      @(negedge CLK);
    end
    if (!bus.obi_gnt_o) begin
      checks++;
      failures++;
      $display("FAIL obi_gnt_timeout actual=0 expected=1");
    end else begin
      e.val  = exp;
      e.mask = mask;
      rsp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    bus.obi_req_i = 1'b0;
    bus.obi_we_i  = 1'b0;
  endtask

  task automatic wr_event(input logic [17:0] v);
    obi(1'b1, 4'h0, 32'(v), 32'h0, 32'hFFFF_FFFF);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic emit_spike(input logic [7:0] a);
    int w = 0;
    AEROUT_ADDR = a;
    AEROUT_REQ  = 1'b1;
    while (!AEROUT_ACK && w < 20) begin idle(1); w++; end
    chk("spike_ack_rise", 32'(AEROUT_ACK), 32'd1);
    AEROUT_REQ = 1'b0;
    w = 0;
    while (AEROUT_ACK && w < 20) begin idle(1); w++; end
    chk("spike_ack_fall", 32'(AEROUT_ACK), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_gnt;
    int w;
    bus.obi_req_i   = 1'b0;
    bus.obi_we_i    = 1'b0;
    bus.obi_addr_i  = 4'h0;
    bus.obi_wdata_i = 32'h0;
    idle(3);
    RST = 1'b0;

    // reset state
    chk("rst_aerin_req", 32'(AERIN_REQ), 32'd0);
    chk("rst_aerin_addr", 32'(AERIN_ADDR), 32'd0);
    chk("rst_aerout_ack", 32'(AEROUT_ACK), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_rvalid", 32'(bus.obi_rvalid_o), 32'd0);
    obi(1'b0, 4'h8, 32'h0, 32'h0002_0000, 32'hFFFF_FFFF);

    // three events through an auto-ACK tinyODIN
    auto_ack = 1'b1;
    aer_q.push_back(18'h00012); wr_event(18'h00012);
    aer_q.push_back(18'h00345); wr_event(18'h00345);
    aer_q.push_back(18'h3FFFF); wr_event(18'h3FFFF);
    idle(30);
    chk("t1_aer_rises", 32'(aer_rises), 32'd3);
    obi(1'b0, 4'h8, 32'h0, 32'h0002_0000, 32'h0007_00FF);

    // input backpressure with ACK held low
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      aer_q.push_back(18'h01000 + 18'(i));
      wr_event(18'h01000 + 18'(i));
    end
    idle(2);
    obi(1'b0, 4'h8, 32'h0, 32'h0007_0008, 32'h0007_00FF);
    aer_q.push_back(18'h02222);
    stall_gnt = 0;
    fork
      wr_event(18'h02222);
      begin
        repeat (3) begin
          @(negedge CLK);
          if (bus.obi_gnt_o) stall_gnt++;
        end
        @(posedge CLK); #1;
        man_ack = 1'b1;
        idle(3);
        man_ack = 1'b0;
      end
    join
    chk("t2_stall_gnt", 32'(stall_gnt), 32'd0);
    auto_ack = 1'b1;
    idle(80);
    obi(1'b0, 4'h8, 32'h0, 32'h0002_0000, 32'h0007_00FF);

    // output spikes and readout with irq
    obi(1'b1, 4'hC, 32'h1, 32'h0, 32'hFFFF_FFFF);
    emit_spike(8'd5);
    emit_spike(8'd7);
    emit_spike(8'd200);
    chk("t3_irq_high", 32'(irq_o), 32'd1);
    obi(1'b0, 4'h4, 32'h0, 32'h8000_0005, 32'hFFFF_FFFF);
    obi(1'b0, 4'h4, 32'h0, 32'h8000_0007, 32'hFFFF_FFFF);
    chk("t3_irq_before_last", 32'(irq_o), 32'd1);
    obi(1'b0, 4'h4, 32'h0, 32'h8000_00C8, 32'hFFFF_FFFF);
    chk("t3_irq_low", 32'(irq_o), 32'd0);
    obi(1'b0, 4'h4, 32'h0, 32'h0, 32'hFFFF_FFFF);

    // output overflow stall and sticky bit
    for (int i = 0; i < 8; i++) emit_spike(8'd10 + 8'(i));
    AEROUT_ADDR = 8'd99;
    AEROUT_REQ  = 1'b1;
    idle(4);
    chk("t4_ack_stalled", 32'(AEROUT_ACK), 32'd0);
    obi(1'b0, 4'h8, 32'h0, 32'h0008_0800, 32'h000A_FF00);
    obi(1'b0, 4'h4, 32'h0, 32'h8000_000A, 32'hFFFF_FFFF);
    w = 0;
    while (!AEROUT_ACK && w < 5) begin idle(1); w++; end
    chk("t4_ack_after_pop", 32'(AEROUT_ACK), 32'd1);
    AEROUT_REQ = 1'b0;
    idle(3);
    obi(1'b1, 4'h8, 32'h0008_0000, 32'h0, 32'hFFFF_FFFF);
    obi(1'b0, 4'h8, 32'h0, 32'h0000_0800, 32'h000A_FF00);
    for (int i = 1; i < 8; i++) obi(1'b0, 4'h4, 32'h0, 32'h8000_000A + 32'(i), 32'hFFFF_FFFF);
    obi(1'b0, 4'h4, 32'h0, 32'h8000_0063, 32'hFFFF_FFFF);

    // flush with one in-flight handshake and four queued events
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    idle(3);
    aer_q.push_back(18'h01500);
    for (int i = 0; i < 5; i++) wr_event(18'h01500 + 18'(i));
    idle(3);
    obi(1'b0, 4'h8, 32'h0, 32'h0004_0004, 32'h0004_00FF);
    obi(1'b1, 4'hC, 32'h3, 32'h0, 32'hFFFF_FFFF);
    idle(1);
    obi(1'b0, 4'h8, 32'h0, 32'h0006_0000, 32'h0006_00FF);
    man_ack = 1'b1;
    idle(3);
    man_ack  = 1'b0;
    auto_ack = 1'b1;
    idle(20);
    obi(1'b0, 4'h8, 32'h0, 32'h0002_0000, 32'h0007_00FF);
    obi(1'b0, 4'hC, 32'h0, 32'h1, 32'hFFFF_FFFF);

    // reset pulse while waiting for ACK
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    idle(3);
    aer_q.push_back(18'h2AAAA);
    wr_event(18'h2AAAA);
    wr_event(18'h15555);
    w = 0;
    while (!AERIN_REQ && w < 10) begin idle(1); w++; end
    chk("t6_req_before_rst", 32'(AERIN_REQ), 32'd1);
    idle(2);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    chk("t6_req_after_rst", 32'(AERIN_REQ), 32'd0);
    chk("t6_irq_after_rst", 32'(irq_o), 32'd0);
    obi(1'b0, 4'h8, 32'h0, 32'h0002_0000, 32'hFFFF_FFFF);
    idle(10);
    chk("t6_no_req_after_rst", 32'(AERIN_REQ), 32'd0);

    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("aer_queue_drained", 32'(aer_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
